// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the core's data-memory port. It accepts one
//   load or store at a time, waits LATENCY cycles, performs the access, and
//   holds the result on the response channel until the requester takes it.
//   Access sizing, load extension, lane placement and error detection follow
//   RV32I funct3 semantics.
//
// Parameters
//   DEPTH_WORDS : 32-bit words of storage (power of two, >= 4)
//   LATENCY     : wait cycles from acceptance to access (1..15)
//
// Ports
//   clk, reset             : clock; asynchronous active-low reset
//   req_valid / req_ready  : request handshake
//   req_we                 : 1 = store, 0 = load
//   req_addr               : byte address
//   req_wdata              : store data, right-justified
//   req_funct3             : RV32I size/sign encoding
//   rsp_valid / rsp_ready  : response handshake (response held until taken)
//   rsp_rdata              : extended load data (0 for stores and errors)
//   rsp_err                : misaligned, out of range or illegal funct3

module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept, access;

    // captured request
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;

    logic [31:0] rdata_q;
    logic        err_q;

    // storage is deliberately left without reset
    logic [31:0] mem [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Next-state / handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        access    = 1'b0;
        case (state_q)
            IDLE: begin
                // gated by reset so the port reads 0 while reset is held
                req_ready = reset;
                if (req_valid && reset) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Access decode on the captured request
    // ------------------------------------------------------------------
    logic             legal, misalign, out_of_range, err;
    logic [IDX_W-1:0] idx;
    logic [31:0]      word, ld_data;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [3:0]       be;
    logic [31:0]      wd;

    always_comb begin
        legal = 1'b0;
        if (we_q) legal = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010);
        else      legal = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010) ||
                          (f3_q == 3'b100) || (f3_q == 3'b101);

        misalign = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                   ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));

        // word index >= DEPTH_WORDS  <=>  any address bit above the index is set
        out_of_range = (addr_q >> (IDX_W + 2)) != 32'd0;

        err = !legal || misalign || out_of_range;
    end

    assign idx     = addr_q[IDX_W+1:2];
    assign word    = mem[idx];
    assign ld_byte = word[8*addr_q[1:0] +: 8];
    assign ld_half = addr_q[1] ? word[31:16] : word[15:0];

    always_comb begin
        ld_data = 32'd0;
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_data = word;
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = 32'd0;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the lanes.
    always_comb begin
        be = 4'b0000;
        wd = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                be = 4'b0001 << addr_q[1:0];
                wd = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be = addr_q[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
            end
            if (access) begin
                err_q   <= err;
                rdata_q <= (err || we_q) ? 32'd0 : ld_data;
            end
        end
    end

    // An aborted store never writes: reset forces IDLE, so access stays low.
    always_ff @(posedge clk) begin
        if (access && we_q && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: randomized and directed requests, expected
// responses from a byte-array reference model pushed into a scoreboard and
// checked by an independent response monitor.

module tb_dmem_responder;

    localparam int DEPTH = 32;
    localparam int LAT   = 3;
    localparam int P     = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic        rsp_ready = 1'b0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #(P/2) clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        longint      t;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mb [DEPTH*4];
    int         n_chk = 0;
    int         n_pass = 0;
    int         bp_hold = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: memory as a plain byte array, little-endian.
    function automatic void model(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [2:0] f3,
                                  output logic [31:0] rd, output logic e);
        int     n;
        bit     legal;
        longint v;
        rd = 32'd0;
        e  = 1'b0;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        n = 1 << f3[1:0];
        if (!legal)                         e = 1'b1;
        else if ((addr % n) != 0)           e = 1'b1;
        else if ((addr / 4) >= DEPTH)       e = 1'b1;
        if (e) return;
        if (we) begin
            for (int i = 0; i < n; i++) mb[addr + i] = 8'(wdata >> (8 * i));
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v += longint'(mb[addr + i]) << (8 * i);
            if (f3 < 3'd4 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
                v -= (longint'(1) << (8 * n));
            rd = 32'(v);
        end
    endfunction

    // Call at a falling edge. Drives junk (possibly valid) while the DUT is
    // not ready, then presents the real request for exactly one edge.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3, input bit push);
        int          w;
        logic [31:0] rd;
        logic        e;
        exp_t        x;
        w = 0;
        while (!req_ready) begin
            if (w++ > 200) begin
                fail("req_ready_timeout");
                req_valid = 1'b0;
                return;
            end
            req_valid  = 1'($urandom % 2);
            req_we     = 1'($urandom % 2);
            req_addr   = $urandom % (DEPTH * 4);
            req_wdata  = $urandom;
            req_funct3 = 3'($urandom % 3);
            @(negedge clk);
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        if (push) begin
            model(we, addr, wdata, f3, rd, e);
            x.rdata = rd;
            x.err   = e;
            x.t     = longint'($time);
            sb.push_back(x);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Response monitor
    logic        prev_v = 1'b0;
    logic        hs_prev = 1'b0;
    logic [31:0] held_rd = 32'd0;
    logic        held_err = 1'b0;

    always @(negedge clk) begin
        exp_t x;
        if (!reset) begin
            prev_v  = 1'b0;
            hs_prev = 1'b0;
            rsp_ready = 1'b0;
        end else begin
            if (hs_prev) begin
                chk("ready_after_hs", {31'd0, req_ready}, 32'd1);
                chk("valid_drop", {31'd0, rsp_valid}, 32'd0);
            end
            hs_prev = 1'b0;
            if (rsp_valid) begin
                chk("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
                if (!prev_v) begin
                    if (sb.size() == 0) fail("unexpected_rsp");
                    else chk("latency", 32'(longint'($time) - sb[0].t), 32'((LAT + 1) * P));
                end else begin
                    chk("hold_rdata", rsp_rdata, held_rd);
                    chk("hold_err", {31'd0, rsp_err}, {31'd0, held_err});
                end
                held_rd  = rsp_rdata;
                held_err = rsp_err;
                if (bp_hold > 0) begin
                    bp_hold--;
                    rsp_ready = 1'b0;
                end else begin
                    rsp_ready = ($urandom % 4) != 0;
                end
                if (rsp_ready) begin
                    hs_prev = 1'b1;
                    if (sb.size() == 0) fail("unexpected_rsp");
                    else begin
                        x = sb.pop_front();
                        chk("rdata", rsp_rdata, x.rdata);
                        chk("err", {31'd0, rsp_err}, {31'd0, x.err});
                    end
                end
            end else begin
                rsp_ready = 1'($urandom % 2);
            end
            prev_v = rsp_valid;
        end
    end

    initial begin
        int          w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [2:0]  legal_f3 [5];
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        // reset state
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ready_out_of_reset", {31'd0, req_ready}, 32'd1);
        @(negedge clk);

        // fill storage so every later load has a defined expectation
        for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), $urandom, 3'd2, 1'b1);

        // word write/read
        issue(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 3'd2, 1'b1);

        // byte/halfword extension
        issue(1'b1, 32'h20, 32'h8001F0FF, 3'd2, 1'b1);
        issue(1'b0, 32'h20, 32'h0, 3'd0, 1'b1);
        issue(1'b0, 32'h21, 32'h0, 3'd4, 1'b1);
        issue(1'b0, 32'h22, 32'h0, 3'd1, 1'b1);
        issue(1'b0, 32'h22, 32'h0, 3'd5, 1'b1);

        // partial stores
        issue(1'b1, 32'h30, 32'h11223344, 3'd2, 1'b1);
        issue(1'b1, 32'h31, 32'h000000AA, 3'd0, 1'b1);
        issue(1'b1, 32'h32, 32'h0000BEEF, 3'd1, 1'b1);
        issue(1'b0, 32'h30, 32'h0, 3'd2, 1'b1);

        // errors leave storage untouched
        issue(1'b1, 32'h40, 32'h5A5AA5A5, 3'd2, 1'b1);
        issue(1'b0, 32'h42, 32'h0, 3'd2, 1'b1);
        issue(1'b1, 32'h41, 32'hFFFFFFFF, 3'd1, 1'b1);
        issue(1'b1, 32'h40, 32'hFFFFFFFF, 3'd3, 1'b1);
        issue(1'b1, 32'(DEPTH * 4), 32'hFFFFFFFF, 3'd2, 1'b1);
        issue(1'b0, 32'(DEPTH * 4), 32'h0, 3'd2, 1'b1);
        issue(1'b0, 32'h40, 32'h0, 3'd2, 1'b1);

        // response backpressure
        bp_hold = 5;
        issue(1'b0, 32'h10, 32'h0, 3'd2, 1'b1);

        // reset mid-operation aborts a store
        issue(1'b1, 32'h50, 32'h12345678, 3'd2, 1'b1);
        issue(1'b0, 32'h50, 32'h0, 3'd2, 1'b1);
        issue(1'b1, 32'h50, 32'hCAFEBABE, 3'd2, 1'b0);
        reset = 1'b0;
        #1;
        chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_rdata", rsp_rdata, 32'd0);
        chk("abort_err", {31'd0, rsp_err}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ready_after_abort", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        issue(1'b0, 32'h50, 32'h0, 3'd2, 1'b1);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            if (($urandom % 8) == 0) f3 = 3'($urandom % 8);
            else                     f3 = legal_f3[$urandom % 5];
            a = $urandom % (DEPTH * 4 + 16);
            if (($urandom % 2) == 0) a = a & ~(32'd1 << f3[1:0]) + 32'd0 & ~((32'd1 << f3[1:0]) - 32'd1);
            issue(1'($urandom % 2), a, $urandom, f3, 1'b1);
        end

        w = 0;
        while (sb.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) fail("drain_timeout");
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory port. It accepts one load or store request at a time from the datapath's load/store path over a valid/ready handshake. Each access is performed after a fixed, configurable wait latency, and the result is returned on a held valid/ready response channel. Byte/halfword/word sizing, load sign/zero extension, byte-lane placement, and alignment/range error detection follow RV32I `funct3` semantics.

## Interface

**Parameters**
- `DEPTH_WORDS`, default 256: number of 32-bit words of storage. Power of two, ≥ 4.
- `LATENCY`, default 2: wait cycles between request acceptance and the access. Range 1–15.

**Ports**
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `req_funct3` in 3: access size/sign, RV32I encoding.
- `rsp_valid` out 1: response present; held until accepted.
- `rsp_ready` in 1: requester accepts the response.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: misaligned, out-of-range or illegal `funct3`.

## Operation

**State machine: IDLE, BUSY, RESP.**
- IDLE: `req_ready`=1. A handshake (`req_valid`&&`req_ready`) at an edge captures we/addr/wdata/funct3 and loads `cnt` = LATENCY−1. Next state is BUSY.
- BUSY: `req_ready`=0.
  - If `cnt`≠0, decrement.
  - If `cnt`==0, perform the access at that edge and go to RESP.
- RESP: `rsp_valid`=1; `rsp_rdata`/`rsp_err` are stable. When `rsp_valid`&&`rsp_ready` at an edge, go to IDLE. Otherwise hold.

**Legal `funct3` values**
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Stores: 000 SB, 001 SH, 010 SW.
- Any other value sets `rsp_err`=1.

**Error conditions (any one sets `rsp_err`=1)**
- Halfword access with `addr[0]`=1.
- Word access with `addr[1:0]`≠00.
- Word index `addr[31:2]` ≥ DEPTH_WORDS.

**On error:** no storage is modified and `rsp_rdata`=0.

**Stores (byte-enable writes)**
- SB writes `wdata[7:0]` to lane `addr[1:0]`.
- SH writes `wdata[15:0]` to lanes {`addr[1]`*2+1, `addr[1]`*2}.
- SW writes all lanes.
- Unselected lanes are unchanged.

**Loads:** select the lane(s) by `addr[1:0]`.
- LB/LH sign-extend to 32 bits.
- LBU/LHU zero-extend.
- LW returns the word unchanged.

**Reset and storage**
- Storage contents are not cleared by reset and are undefined until written.
- While `reset`=0: state=IDLE, `cnt`=0, `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- After `reset` deasserts, `req_ready`=1 from the first cycle.
- Reset asserted mid-transaction (BUSY or RESP) aborts the transaction. A store that has not yet reached its access edge is not performed. A response pending in RESP is dropped.

## Timing

- Acceptance at edge k. The access occurs at edge k+LATENCY. `rsp_valid` is high in the cycle after that edge.
- `req_ready` is 0 from edge k until the edge at which the response handshake completes. The next request can be accepted at the following edge at the earliest.
- Minimum request spacing is LATENCY+2 edges.
- `req_*` inputs are ignored outside IDLE.
- If `rsp_ready` is held low, RESP persists indefinitely and outputs stay constant.
- A load issued after a completed store to the same word returns the updated data.

## Test plan

1. **Word write/read.** After reset, SW addr 0x10 data 0xDEADBEEF, then LW 0x10.
   - `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
   - `rsp_valid` rises exactly LATENCY cycles after acceptance of each request.
2. **Byte and halfword extension.** SW 0x20 = 0x8001F0FF, then:
   - LB 0x20 → 0xFFFFFFFF
   - LBU 0x21 → 0x000000F0
   - LH 0x22 → 0xFFFF8001
   - LHU 0x22 → 0x00008001
3. **Partial stores.** SW 0x30 = 0x11223344; SB 0x31 with wdata 0xAA; SH 0x32 with wdata 0xBEEF; then LW 0x30 → 0xBEEFAA44.
4. **Errors.** All of the following return `rsp_err`=1 and `rsp_rdata`=0, and a following LW 0x40 still returns its prior value:
   - LW 0x42
   - SH 0x41
   - funct3=011
   - LW at byte address 4*DEPTH_WORDS
5. **Response backpressure.** Hold `rsp_ready`=0 for 5 cycles during a LW.
   - `rsp_valid` and `rsp_rdata` stay constant.
   - `req_ready`=0 throughout.
   - `req_ready` returns to 1 in the cycle after the handshake edge.
6. **Reset mid-operation.** SW 0x50 = 0x12345678, then SW 0x50 = 0xCAFEBABE aborted by asserting `reset` while in BUSY.
   - All outputs go to their reset values.
   - A subsequent LW 0x50 returns 0x12345678.
